// File: rtl/div_iterative_pkg.sv
// Shared definitions for the iterative signed divider: widths, FSM encodings, constants.
`timescale 1ns/1ps
package div_iterative_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/div_iterative_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixes.
`timescale 1ns/1ps
module div_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);

    assign out = neg ? (~in + 1'b1) : in;

endmodule

// File: rtl/div_iterative.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, MSB first.
`timescale 1ns/1ps
module div_iterative
    import div_iterative_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    // state    | meaning
    // DIV_IDLE | waiting for ctrl_div; operands sampled on the start edge
    // DIV_RUN  | one trial subtraction per edge (one edge only for divide-by-zero)
    // DIV_DONE | results valid, data_resultRDY high for this single cycle

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e state, state_nx;

    logic [WIDTH-1:0] dvd, dvs, q, rem;
    logic [CNT_W-1:0] cnt;
    logic             sign_q, sign_r, div_zero, ovf;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH:0]   rem_sh, diff;
    logic             keep, last;
    logic [WIDTH-1:0] q_new, rem_new, q_src, rem_src, q_fix, rem_fix;

    div_negate #(.WIDTH(WIDTH)) u_abs_a (.in(data_operandA), .neg(data_operandA[WIDTH-1]), .out(abs_a));
    div_negate #(.WIDTH(WIDTH)) u_abs_b (.in(data_operandB), .neg(data_operandB[WIDTH-1]), .out(abs_b));
    div_negate #(.WIDTH(WIDTH)) u_fix_q (.in(q_src), .neg(sign_q), .out(q_fix));
    div_negate #(.WIDTH(WIDTH)) u_fix_r (.in(rem_src), .neg(sign_r), .out(rem_fix));

    // Magnitudes are unsigned: |INT_MIN| is 2^31, so the subtract is 33 bits wide.
    assign bit_idx = IDX_W'(LAST_CNT - cnt);
    assign rem_sh  = {rem, dvd[bit_idx]};
    assign diff    = rem_sh - {1'b0, dvs};
    assign keep    = ~diff[WIDTH];
    assign rem_new = keep ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign last    = div_zero || (cnt == LAST_CNT);

    always_comb begin
        q_new          = q;
        q_new[bit_idx] = keep;
    end

    // Divide-by-zero reports quotient 0 and the dividend as remainder.
    assign q_src   = div_zero ? '0 : q_new;
    assign rem_src = div_zero ? dvd : rem_new;

    assign busy = (state != DIV_IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Divide-by-zero still passes through RUN for one edge so RDY lands between E1 and E2.
    always_comb begin
        state_nx = state;
        case (state)
            DIV_IDLE: if (ctrl_div) state_nx = DIV_RUN;
            DIV_RUN:  if (last)     state_nx = DIV_DONE;
            DIV_DONE:               state_nx = DIV_IDLE;
            default:                state_nx = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dvd            <= '0;
            dvs            <= '0;
            q              <= '0;
            rem            <= '0;
            cnt            <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            div_zero       <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (ctrl_div) begin
                        dvd            <= abs_a;
                        dvs            <= abs_b;
                        sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        sign_r         <= data_operandA[WIDTH-1];
                        rem            <= '0;
                        q              <= '0;
                        cnt            <= '0;
                        div_zero       <= (data_operandB == '0);
                        ovf            <= (data_operandA == INT_MIN) && (data_operandB == '1);
                        data_exception <= 1'b0;
                    end
                end
                DIV_RUN: begin
                    q   <= q_new;
                    rem <= rem_new;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        data_result    <= q_fix;
                        data_remainder <= rem_fix;
                        data_exception <= div_zero | ovf;
                        data_resultRDY <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iterative.sv
// Directed bench for div_iterative: latency, signs, divide-by-zero, overflow, ignored starts, reset.
`timescale 1ns/1ps
module tb_div_iterative;

    logic        clock;
    logic        reset_n;
    logic        ctrl_div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_cmp;
    int n_bad;

    div_iterative dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Start at E0, then watch 40 edges; first is the edge count after E0 at which RDY was seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [31:0] rem,
                          output logic exc, output int first, output int pulses);
        first  = 0;
        pulses = 0;
        res    = 32'hDEAD_BEEF;
        rem    = 32'hDEAD_BEEF;
        exc    = 1'bx;
        ctrl_div      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_div      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                if (first == 0) begin
                    first = k;
                    res   = data_result;
                    rem   = data_remainder;
                    exc   = data_exception;
                end
                pulses++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        ctrl_div      = 1'b0;
        data_operandA = 32'h1234_5678;
        data_operandB = 32'h0000_0003;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (data_result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 00000000", data_result); end
        n_cmp++; if (data_remainder !== 32'h0) begin n_bad++; $display("FAIL reset_remainder: got %h want 00000000", data_remainder); end
        n_cmp++; if (data_exception !== 1'b0) begin n_bad++; $display("FAIL reset_exception: got %b want 0", data_exception); end
        n_cmp++; if (data_resultRDY !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        logic [31:0] res, rem;
        logic        exc;
        int          first, pulses;
        run_op(32'd100, 32'd7, res, rem, exc, first, pulses);
        n_cmp++; if (first !== 32) begin n_bad++; $display("FAIL basic_latency: got %0d want 32", first); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL basic_rdy_pulses: got %0d want 1", pulses); end
        n_cmp++; if (res !== 32'd14) begin n_bad++; $display("FAIL basic_result: got %h want 0000000e", res); end
        n_cmp++; if (rem !== 32'd2) begin n_bad++; $display("FAIL basic_remainder: got %h want 00000002", rem); end
        n_cmp++; if (exc !== 1'b0) begin n_bad++; $display("FAIL basic_exception: got %b want 0", exc); end
        n_cmp++; if (data_result !== 32'd14) begin n_bad++; $display("FAIL basic_result_held: got %h want 0000000e", data_result); end
    endtask

    task automatic test_signs();
        logic [31:0] res, rem;
        logic        exc;
        int          first, pulses;
        run_op(32'hFFFF_FF9C, 32'd7, res, rem, exc, first, pulses);
        n_cmp++; if (res !== 32'hFFFF_FFF2) begin n_bad++; $display("FAIL neg_dvd_result: got %h want fffffff2", res); end
        n_cmp++; if (rem !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL neg_dvd_remainder: got %h want fffffffe", rem); end
        run_op(32'd100, 32'hFFFF_FFF9, res, rem, exc, first, pulses);
        n_cmp++; if (res !== 32'hFFFF_FFF2) begin n_bad++; $display("FAIL neg_dvs_result: got %h want fffffff2", res); end
        n_cmp++; if (rem !== 32'd2) begin n_bad++; $display("FAIL neg_dvs_remainder: got %h want 00000002", rem); end
        run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, res, rem, exc, first, pulses);
        n_cmp++; if (res !== 32'd14) begin n_bad++; $display("FAIL both_neg_result: got %h want 0000000e", res); end
        n_cmp++; if (rem !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL both_neg_remainder: got %h want fffffffe", rem); end
    endtask

    task automatic test_div_zero();
        logic [31:0] res, rem;
        logic        exc;
        int          first, pulses;
        run_op(32'd5, 32'd0, res, rem, exc, first, pulses);
        n_cmp++; if (first !== 1) begin n_bad++; $display("FAIL dz_latency: got %0d want 1", first); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL dz_rdy_pulses: got %0d want 1", pulses); end
        n_cmp++; if (exc !== 1'b1) begin n_bad++; $display("FAIL dz_exception: got %b want 1", exc); end
        n_cmp++; if (res !== 32'd0) begin n_bad++; $display("FAIL dz_result: got %h want 00000000", res); end
        n_cmp++; if (rem !== 32'd5) begin n_bad++; $display("FAIL dz_remainder: got %h want 00000005", rem); end
        n_cmp++; if (data_exception !== 1'b1) begin n_bad++; $display("FAIL dz_exception_held: got %b want 1", data_exception); end
        run_op(32'd9, 32'd3, res, rem, exc, first, pulses);
        n_cmp++; if (exc !== 1'b0) begin n_bad++; $display("FAIL dz_clear_exception: got %b want 0", exc); end
        n_cmp++; if (res !== 32'd3) begin n_bad++; $display("FAIL dz_next_result: got %h want 00000003", res); end
        n_cmp++; if (first !== 32) begin n_bad++; $display("FAIL dz_next_latency: got %0d want 32", first); end
    endtask

    task automatic test_overflow();
        logic [31:0] res, rem;
        logic        exc;
        int          first, pulses;
        run_op(32'h8000_0000, 32'hFFFF_FFFF, res, rem, exc, first, pulses);
        n_cmp++; if (res !== 32'h8000_0000) begin n_bad++; $display("FAIL ovf_result: got %h want 80000000", res); end
        n_cmp++; if (exc !== 1'b1) begin n_bad++; $display("FAIL ovf_exception: got %b want 1", exc); end
        n_cmp++; if (rem !== 32'd0) begin n_bad++; $display("FAIL ovf_remainder: got %h want 00000000", rem); end
        n_cmp++; if (first !== 32) begin n_bad++; $display("FAIL ovf_latency: got %0d want 32", first); end
        run_op(32'h8000_0000, 32'd2, res, rem, exc, first, pulses);
        n_cmp++; if (res !== 32'hC000_0000) begin n_bad++; $display("FAIL intmin_div2_result: got %h want c0000000", res); end
        n_cmp++; if (exc !== 1'b0) begin n_bad++; $display("FAIL intmin_div2_exception: got %b want 0", exc); end
        run_op(32'h8000_0000, 32'd7, res, rem, exc, first, pulses);
        n_cmp++; if (res !== 32'hEDB6_DB6E) begin n_bad++; $display("FAIL intmin_div7_result: got %h want edb6db6e", res); end
        n_cmp++; if (rem !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL intmin_div7_remainder: got %h want fffffffe", rem); end
        run_op(32'd0, 32'd7, res, rem, exc, first, pulses);
        n_cmp++; if (first !== 32) begin n_bad++; $display("FAIL zero_dvd_latency: got %0d want 32", first); end
        n_cmp++; if (res !== 32'd0 || rem !== 32'd0) begin n_bad++; $display("FAIL zero_dvd_result: got %h/%h want 00000000/00000000", res, rem); end
        run_op(32'h7FFF_FFFF, 32'h8000_0000, res, rem, exc, first, pulses);
        n_cmp++; if (res !== 32'd0 || rem !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL max_by_min: got %h/%h want 00000000/7fffffff", res, rem); end
    endtask

    task automatic test_ignore_start();
        int          first, pulses;
        logic [31:0] res;
        first  = 0;
        pulses = 0;
        res    = 32'hDEAD_BEEF;
        ctrl_div      = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                ctrl_div      = 1'b1;
                data_operandA = 32'd1;
                data_operandB = 32'd1;
            end
            @(posedge clock);
            #1;
            if (k == 10) begin
                ctrl_div = 1'b0;
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ignore_busy: got %b want 1", busy); end
            end
            if (data_resultRDY === 1'b1) begin
                if (first == 0) begin
                    first = k;
                    res   = data_result;
                end
                pulses++;
            end
        end
        n_cmp++; if (first !== 32) begin n_bad++; $display("FAIL ignore_latency: got %0d want 32", first); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ignore_rdy_pulses: got %0d want 1", pulses); end
        n_cmp++; if (res !== 32'd10) begin n_bad++; $display("FAIL ignore_result: got %h want 0000000a", res); end
    endtask

    task automatic test_back_to_back();
        int          first, pulses;
        logic [31:0] res;
        first  = 0;
        pulses = 0;
        res    = 32'hDEAD_BEEF;
        ctrl_div      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
        repeat (33) @(posedge clock);
        #1;
        ctrl_div      = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd3;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                if (first == 0) begin
                    first = k;
                    res   = data_result;
                end
                pulses++;
            end
        end
        n_cmp++; if (first !== 32) begin n_bad++; $display("FAIL b2b_latency: got %0d want 32", first); end
        n_cmp++; if (res !== 32'd3) begin n_bad++; $display("FAIL b2b_result: got %h want 00000003", res); end
    endtask

    task automatic test_reset_midrun();
        int pulses;
        pulses = 0;
        ctrl_div      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 20) reset_n = 1'b0;
            @(posedge clock);
            #1;
            if (k == 20) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
                n_cmp++; if (data_result !== 32'h0) begin n_bad++; $display("FAIL rst_mid_result: got %h want 00000000", data_result); end
                n_cmp++; if (data_remainder !== 32'h0) begin n_bad++; $display("FAIL rst_mid_remainder: got %h want 00000000", data_remainder); end
                n_cmp++; if (data_exception !== 1'b0) begin n_bad++; $display("FAIL rst_mid_exception: got %b want 0", data_exception); end
                reset_n = 1'b1;
            end
            if (data_resultRDY === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rst_mid_no_rdy: got %0d pulses want 0", pulses); end
        n_cmp++; if (data_result !== 32'h0) begin n_bad++; $display("FAIL rst_mid_result_after: got %h want 00000000", data_result); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
